menu_ctrl: RTL and testbench

MENU_CTRL -- requirements
Module: menu_ctrl

---
 rtl/menu_ctrl_pkg.sv | 29 ++
 rtl/menu_ctrl_if.sv | 26 ++
 rtl/seq_divider.sv | 81 ++++++++
 rtl/menu_ctrl.sv | 149 ++++++++++++++
 tb/tb_menu_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/menu_ctrl_pkg.sv
// Shared definitions for the typing-game menu controller.
//   state_e        : controller FSM encoding
//   TIME_TBL/WORD_TBL : selectable values indexed by the 2-bit menu index
//   WPM_MAX/ACC_MAX   : clamp limits applied to incoming game results
package menu_ctrl_pkg;

  typedef enum logic [2:0] {
    MENU    = 3'd0,
    GAME    = 3'd1,
    UPDATE  = 3'd2,
    DIV_WPM = 3'd3,
    DIV_ACC = 3'd4
  } state_e;

  localparam logic [3:0][6:0] TIME_TBL = {7'd120, 7'd60, 7'd30, 7'd15};
  localparam logic [3:0][6:0] WORD_TBL = {7'd100, 7'd50, 7'd25, 7'd10};

  localparam logic [9:0] WPM_MAX = 10'd999;
  localparam logic [9:0] ACC_MAX = 10'd100;

  function automatic logic [6:0] value_of(logic m, logic [1:0] idx);
    return m ? WORD_TBL[idx] : TIME_TBL[idx];
  endfunction

  function automatic logic [9:0] clamp10(logic [9:0] x, logic [9:0] lim);
    return (x > lim) ? lim : x;
  endfunction

endpackage

// File: rtl/menu_ctrl_if.sv
// Menu controller bus: key pulses and game results in, menu/stat outputs out.
//   slave  : controller side
//   master : driver side (game core / keypad / bench)
interface menu_if;
  import menu_ctrl_pkg::*;

  logic       btn_up, btn_down, btn_mode, btn_enter;
  logic       game_done;
  logic [9:0] res_wpm, res_acc;
  logic       mode;
  logic [6:0] value;
  logic       start, in_game, busy;
  logic [9:0] wpm_best, wpm_average, acc_best, acc_average;

  modport slave (
    input  btn_up, btn_down, btn_mode, btn_enter, game_done, res_wpm, res_acc,
    output mode, value, start, in_game, busy,
           wpm_best, wpm_average, acc_best, acc_average
  );

  modport master (
    output btn_up, btn_down, btn_mode, btn_enter, game_done, res_wpm, res_acc,
    input  mode, value, start, in_game, busy,
           wpm_best, wpm_average, acc_best, acc_average
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, SUM_W cycles per division.
//   start    : load dividend/divisor (overrides a division in flight)
//   done     : high in the last step cycle; quotient is valid with it
//   quotient : low OUT_W bits of dividend / divisor (divisor must be nonzero)
module seq_divider
  import menu_ctrl_pkg::*;
#(
  parameter int SUM_W = 18,
  parameter int CNT_W = 8,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);
  localparam int SC_W = $clog2(SUM_W);
  localparam logic [SC_W-1:0] LAST = SC_W'(SUM_W - 1);

  logic             run_q, run_d;
  logic [SUM_W-1:0] quo_q, quo_d, step_quo;
  logic [CNT_W-1:0] rem_q, rem_d, dvs_q, dvs_d, step_rem;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]   shifted, diff;
  logic             ge;

  // Remainder stays below the divisor, so CNT_W+1 bits hold the shifted value;
  // the borrow bit of the trial subtraction tells whether it fits.
  always_comb begin
    shifted  = {rem_q, quo_q[SUM_W-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = ~diff[CNT_W];
    step_rem = ge ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    step_quo = {quo_q[SUM_W-2:0], ge};
  end

  always_comb begin
    run_d    = run_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    quotient = step_quo[OUT_W-1:0];
    if (run_q) begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
    if (start) begin
      run_d = 1'b1;
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/menu_ctrl.sv
// Typing-game menu controller: time/word selection, game launch, and
// best/average WPM and accuracy statistics.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : menu_if.slave (keys, game results, menu and statistic outputs)
module menu_ctrl
  import menu_ctrl_pkg::*;
#(
  parameter int SUM_W = 18,
  parameter int CNT_W = 8
) (
  input logic   clk,
  input logic   rst,
  menu_if.slave bus
);
  state_e           state_q, state_d;
  logic             mode_q, mode_d, start_q, start_d;
  logic [1:0]       idx_q, idx_d;
  logic [9:0]       wres_q, wres_d, ares_q, ares_d;
  logic [9:0]       wbest_q, wbest_d, abest_q, abest_d;
  logic [9:0]       wavg_q, wavg_d, aavg_q, aavg_d;
  logic [SUM_W-1:0] wsum_q, wsum_d, asum_q, asum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [9:0]       div_quot;

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W), .OUT_W(10)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    start_d      = 1'b0;
    wres_d       = wres_q;
    ares_d       = ares_q;
    wbest_d      = wbest_q;
    abest_d      = abest_q;
    wavg_d       = wavg_q;
    aavg_d       = aavg_q;
    wsum_d       = wsum_q;
    asum_d       = asum_q;
    cnt_d        = cnt_q;
    div_start    = 1'b0;
    div_dividend = asum_q;
    div_divisor  = cnt_q;
    case (state_q)
      MENU: begin
        if (bus.btn_enter) begin
          start_d = 1'b1;
          state_d = GAME;
        end else if (bus.btn_mode) begin
          mode_d = ~mode_q;
        end else if (bus.btn_up ^ bus.btn_down) begin
          idx_d = bus.btn_up ? idx_q + 2'd1 : idx_q - 2'd1;
        end
      end
      GAME: begin
        // Results are only valid alongside game_done, so capture them here.
        if (bus.game_done) begin
          wres_d  = clamp10(bus.res_wpm, WPM_MAX);
          ares_d  = clamp10(bus.res_acc, ACC_MAX);
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (wres_q > wbest_q) wbest_d = wres_q;
        if (ares_q > abest_q) abest_d = ares_q;
        if (cnt_q != {CNT_W{1'b1}}) begin
          wsum_d       = wsum_q + SUM_W'(wres_q);
          asum_d       = asum_q + SUM_W'(ares_q);
          cnt_d        = cnt_q + 1'b1;
          div_start    = 1'b1;
          div_dividend = wsum_d;
          div_divisor  = cnt_d;
          state_d      = DIV_WPM;
        end else begin
          state_d = MENU;
        end
      end
      DIV_WPM: begin
        // Hand the shared divider straight over to the accuracy division.
        if (div_done) begin
          wavg_d    = div_quot;
          div_start = 1'b1;
          state_d   = DIV_ACC;
        end
      end
      DIV_ACC: begin
        if (div_done) begin
          aavg_d  = div_quot;
          state_d = MENU;
        end
      end
      default: state_d = MENU;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MENU;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      start_q <= 1'b0;
      wres_q  <= '0;
      ares_q  <= '0;
      wbest_q <= '0;
      abest_q <= '0;
      wavg_q  <= '0;
      aavg_q  <= '0;
      wsum_q  <= '0;
      asum_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      wres_q  <= wres_d;
      ares_q  <= ares_d;
      wbest_q <= wbest_d;
      abest_q <= abest_d;
      wavg_q  <= wavg_d;
      aavg_q  <= aavg_d;
      wsum_q  <= wsum_d;
      asum_q  <= asum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mode        = mode_q;
  assign bus.value       = value_of(mode_q, idx_q);
  assign bus.start       = start_q;
  assign bus.in_game     = (state_q == GAME);
  assign bus.busy        = (state_q == UPDATE) || (state_q == DIV_WPM) || (state_q == DIV_ACC);
  assign bus.wpm_best    = wbest_q;
  assign bus.wpm_average = wavg_q;
  assign bus.acc_best    = abest_q;
  assign bus.acc_average = aavg_q;
endmodule

// File: tb/tb_menu_ctrl.sv
// Bench for menu_ctrl: directed key/game sequences; expected start events and
// statistic updates go into queues that a negedge monitor pops and compares.
module tb_menu_ctrl;
  import menu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  menu_if bus();

  menu_ctrl #(.SUM_W(18), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [9:0] wb, wa, ab, aa; int blen; } stat_t;
  typedef struct { logic m; logic [6:0] v; } start_t;
  stat_t  stat_q[$];
  start_t start_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic  busy_prev = 1'b0, start_prev = 1'b0;
  int    blen = 0;
  stat_t se;
  start_t st;

  always @(negedge clk) begin
    if (!rst) begin
      busy_prev  = 1'b0;
      start_prev = 1'b0;
      blen       = 0;
    end else begin
      if (bus.start) begin
        chk("start_width", start_prev, 0);
        if (start_q.size() == 0) chk("start_unexpected", start_q.size(), 1);
        else begin
          st = start_q.pop_front();
          chk("start_mode", bus.mode, st.m);
          chk("start_value", bus.value, st.v);
          chk("start_in_game", bus.in_game, 1);
        end
      end
      if (bus.busy) blen++;
      else if (busy_prev) begin
        if (stat_q.size() == 0) chk("stat_unexpected", stat_q.size(), 1);
        else begin
          se = stat_q.pop_front();
          chk("wpm_best", bus.wpm_best, se.wb);
          chk("wpm_average", bus.wpm_average, se.wa);
          chk("acc_best", bus.acc_best, se.ab);
          chk("acc_average", bus.acc_average, se.aa);
          chk("busy_cycles", blen, se.blen);
        end
        blen = 0;
      end
      busy_prev  = bus.busy;
      start_prev = bus.start;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(logic u, logic d, logic m, logic e);
    bus.btn_up = u; bus.btn_down = d; bus.btn_mode = m; bus.btn_enter = e;
    tick();
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_mode = 0; bus.btn_enter = 0;
  endtask

  task automatic finish_game(logic [9:0] w, logic [9:0] a);
    int k;
    bus.res_wpm = w; bus.res_acc = a; bus.game_done = 1'b1;
    tick();
    bus.game_done = 1'b0;
    k = 0;
    while (bus.busy === 1'b1 && k < 100) begin tick(); k++; end
    chk("busy_bound", (k < 100), 1);
    tick(2);
  endtask

  task automatic zero_outputs(string tag);
    chk({tag, "_mode"}, bus.mode, 0);
    chk({tag, "_value"}, bus.value, 15);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_in_game"}, bus.in_game, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_stats"}, {bus.wpm_best, bus.wpm_average, bus.acc_best} | 30'(bus.acc_average), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  int   mw, ma, mcnt;
  logic [9:0] mwb, mab, w, a;

  initial begin
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_mode = 0; bus.btn_enter = 0;
    bus.game_done = 0; bus.res_wpm = '0; bus.res_acc = '0;
    tick(3);
    rst = 1'b1;
    tick();
    zero_outputs("reset");

    // menu navigation
    press(0, 1, 0, 0); chk("down_wrap_value", bus.value, 120);
    press(0, 0, 1, 0); chk("mode_toggle", bus.mode, 1); chk("mode_value", bus.value, 100);
    press(1, 1, 0, 0); chk("up_down_hold", bus.value, 100);
    press(1, 0, 0, 0); chk("up_wrap_value", bus.value, 10);
    press(0, 1, 0, 0); chk("down_value", bus.value, 100);

    // game_done outside GAME is ignored
    bus.game_done = 1'b1; bus.res_wpm = 10'd500; bus.res_acc = 10'd50;
    tick();
    bus.game_done = 1'b0;
    tick(2);
    chk("stray_done_busy", bus.busy, 0);
    chk("stray_done_best", bus.wpm_best, 0);

    // game 1: enter+mode together, keys ignored during the game
    start_q.push_back('{1'b1, 7'd100});
    stat_q.push_back('{10'd40, 10'd40, 10'd90, 10'd90, 37});
    press(0, 0, 1, 1);
    chk("enter_over_mode", bus.mode, 1);
    press(1, 0, 1, 0);
    chk("game_keys_mode", bus.mode, 1);
    chk("game_keys_value", bus.value, 100);
    finish_game(10'd40, 10'd90);

    // game 2
    start_q.push_back('{1'b1, 7'd100});
    stat_q.push_back('{10'd61, 10'd50, 10'd100, 10'd95, 37});
    press(0, 0, 0, 1);
    finish_game(10'd61, 10'd100);

    // game 3: clamping (sums 1100 and 290 over 3 games)
    start_q.push_back('{1'b1, 7'd100});
    stat_q.push_back('{10'd999, 10'd366, 10'd100, 10'd96, 37});
    press(0, 0, 0, 1);
    finish_game(10'd1023, 10'd200);

    // reset in the middle of the WPM division
    start_q.push_back('{1'b1, 7'd100});
    press(0, 0, 0, 1);
    bus.res_wpm = 10'd500; bus.res_acc = 10'd50; bus.game_done = 1'b1;
    tick();
    bus.game_done = 1'b0;
    tick(11);
    rst = 1'b0;
    #1;
    zero_outputs("async_rst");
    tick();
    rst = 1'b1;
    tick();
    zero_outputs("post_rst");
    press(1, 0, 0, 0); chk("post_rst_key", bus.value, 30);
    press(0, 1, 0, 0);

    // saturate the game counter, then one more game
    mw = 0; ma = 0; mcnt = 0; mwb = '0; mab = '0;
    for (int i = 0; i < 255; i++) begin
      w = 10'(50 + i % 7);
      a = 10'(70 + i % 5);
      mw += int'(w); ma += int'(a); mcnt++;
      if (w > mwb) mwb = w;
      if (a > mab) mab = a;
      start_q.push_back('{1'b0, 7'd15});
      stat_q.push_back('{mwb, 10'(mw / mcnt), mab, 10'(ma / mcnt), 37});
      press(0, 0, 0, 1);
      finish_game(w, a);
    end
    start_q.push_back('{1'b0, 7'd15});
    stat_q.push_back('{10'd999, 10'(mw / mcnt), 10'd100, 10'(ma / mcnt), 1});
    press(0, 0, 0, 1);
    finish_game(10'd1000, 10'd100);

    tick(3);
    chk("start_queue_empty", start_q.size(), 0);
    chk("stat_queue_empty", stat_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
